// File: rtl/mod_seq_pkg.sv
// Shared types and constants for the BPSK transmit sequencer.
package mod_seq_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  localparam logic [1:0] MODE_IDLE    = 2'b00;
  localparam logic [1:0] MODE_BPSK    = 2'b01;
  localparam logic [1:0] MODE_CARRIER = 2'b10;

  function automatic int half_table(input int aw);
    return 1 << (aw - 1);
  endfunction

  localparam int HALF_TABLE = half_table(7);
endpackage

// File: rtl/sample_tick_gen.sv
// Divides clk down to the DAC/ADC sample rate; counter parks at 0 while disabled.
module sample_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic tick,
  output logic clk_DA,
  output logic clk_AD
);
  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          div_cnt <= '0;
    else if (!en || tick)  div_cnt <= '0;
    else                   div_cnt <= div_cnt + 1'b1;
  end

  assign tick   = en && (div_cnt == DW'(CLK_DIV - 1));
  // Sample clocks are derived from the counter so they drop with the enable.
  assign clk_DA = en && (div_cnt < DW'(CLK_DIV / 2));
  assign clk_AD = en && !clk_DA;
endmodule

// File: rtl/mod_sequencer.sv
// Symbol-aligned BPSK sequencer: sine table addressing, phase flips, bit handshake.
// Define MOD_SEQ_DPSK_EN for differential (phase XOR bit) encoding.
module mod_sequencer
  import mod_seq_pkg::*;
#(
  parameter int CLK_DIV         = 4,
  parameter int CARRIER_PER_SYM = 2,
  parameter int ADDR_W          = 7
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        mode_req,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              bit_ready,
  output logic [ADDR_W-1:0] address,
  output logic              clk_DA,
  output logic              clk_AD,
  output logic              blank_DA_n,
  output logic              sync_DA_n,
  output logic              sym_strobe,
  output logic              busy,
  output logic              underrun
);
  localparam int CW = (CARRIER_PER_SYM > 1) ? $clog2(CARRIER_PER_SYM) : 1;
  localparam logic [ADDR_W-1:0] HALF   = ADDR_W'(half_table(ADDR_W));
  localparam logic [CW-1:0]     CAR_MX = CW'(CARRIER_PER_SYM - 1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] base, base_nx;
  logic [CW-1:0]     car_cnt, car_nx;
  logic              phase, phase_nx, bit_phase;
  logic              run, tick, base_wrap, sym_end;

  assign run = (state == RUN);

  sample_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (run),
    .tick    (tick),
    .clk_DA  (clk_DA),
    .clk_AD  (clk_AD)
  );

`ifdef MOD_SEQ_DPSK_EN
  assign bit_phase = phase ^ bit_in;
`else
  assign bit_phase = bit_in;
`endif

  assign base_wrap = tick && (base == '1);
  assign sym_end   = base_wrap && (car_cnt == CAR_MX);

  always_comb begin
    state_nx  = state;
    base_nx   = base;
    car_nx    = car_cnt;
    phase_nx  = phase;
    bit_ready = 1'b0;
    underrun  = 1'b0;
    case (state)
      IDLE: begin
        base_nx  = '0;
        car_nx   = '0;
        phase_nx = 1'b0;
        if (mode_req == MODE_BPSK)         state_nx = LOAD;
        else if (mode_req == MODE_CARRIER) state_nx = RUN;
      end
      LOAD: begin
        bit_ready = 1'b1;
        if (bit_valid) begin
          phase_nx = bit_phase;
          state_nx = RUN;
        end else if (mode_req != MODE_BPSK && mode_req != MODE_CARRIER) begin
          state_nx = IDLE;
        end
      end
      RUN: begin
        if (tick) base_nx = base + 1'b1;
        if (base_wrap) car_nx = (car_cnt == CAR_MX) ? '0 : car_cnt + 1'b1;
        // Mode is only honoured here; mid-symbol requests wait for this cycle.
        if (sym_end) begin
          case (mode_req)
            MODE_BPSK: begin
              bit_ready = 1'b1;
              if (bit_valid) phase_nx = bit_phase;
              else           underrun = 1'b1;
            end
            MODE_CARRIER: phase_nx = 1'b0;
            default: begin
              state_nx = IDLE;
              phase_nx = 1'b0;
            end
          endcase
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      base    <= '0;
      car_cnt <= '0;
      phase   <= 1'b0;
      address <= '0;
    end else begin
      state   <= state_nx;
      base    <= base_nx;
      car_cnt <= car_nx;
      phase   <= phase_nx;
      address <= base_nx + (phase_nx ? HALF : '0);
    end
  end

  assign sym_strobe = run && sym_end;
  assign blank_DA_n = run;
  assign sync_DA_n  = !(run && base == '0 && car_cnt == '0);
  assign busy       = (state != IDLE);
endmodule

// File: doc/mod_sequencer.md
# mod_sequencer

Sequencer for the BPSK transmit datapath: derives the DAC/ADC sample strobes from `clk`, generates the 7-bit sine lookup-table address, and applies a per-symbol 180° phase offset from the data bit. Data bits are pulled from the PN source through a valid/ready handshake. Mode changes are accepted only on symbol boundaries. It sits between the PN source and the lookup table, replacing free-running address counting with symbol-aligned control.

## Interface
- `CLK_DIV`, 4: `clk` cycles per DAC sample; even, ≥2.
- `CARRIER_PER_SYM`, 2: full 128-sample carrier periods per symbol; ≥1.
- `ADDR_W`, 7: table address width; table depth is 2^ADDR_W.
- `clk` in 1: system clock; the only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `mode_req` in 2: 00 idle, 01 BPSK, 10 unmodulated carrier, 11 treated as idle.
- `bit_in` in 1: data bit from the PN source.
- `bit_valid` in 1: `bit_in` is valid.
- `bit_ready` out 1: the sequencer accepts a bit this cycle.
- `address` out ADDR_W: lookup-table address.
- `clk_DA` out 1: DAC sample clock.
- `clk_AD` out 1: ADC sample clock, `~clk_DA` while running.
- `blank_DA_n` out 1: DAC blanking, active low.
- `sync_DA_n` out 1: symbol-start marker, active low.
- `sym_strobe` out 1: one-`clk` pulse on the last cycle of each symbol.
- `busy` out 1: high whenever the state is not IDLE.
- `underrun` out 1: one-`clk` pulse when a bit is missing at a symbol boundary.

## Operation
- Reset values: `address`=0, `clk_DA`=0, `clk_AD`=0, `blank_DA_n`=0, `sync_DA_n`=1. `bit_ready`, `sym_strobe`, `busy` and `underrun` are all 0. The state is IDLE and all counters are 0.
- Counters:
  - `div_cnt` counts 0..CLK_DIV-1; a tick occurs when `div_cnt`==CLK_DIV-1.
  - `base` (ADDR_W bits) increments on each tick and wraps from 127 to 0.
  - `car_cnt` counts 0..CARRIER_PER_SYM-1 and increments when `base` wraps.
- The symbol end is the tick where `base`==127 and `car_cnt`==CARRIER_PER_SYM-1.
- `address` = (`base` + (`phase` ? 2^(ADDR_W-1) : 0)) mod 2^ADDR_W. The address is registered.
- States:
  - IDLE: counters are held at 0 and `blank_DA_n`=0.
    - `mode_req`=01 moves to LOAD.
    - `mode_req`=10 moves to RUN with `phase`=0.
  - LOAD: `bit_ready`=1.
    - On `bit_valid`&`bit_ready`, `phase` is set from the bit and the state moves to RUN with counters at 0.
    - If `mode_req` drops to 00 or 11, the state returns to IDLE.
  - RUN: `blank_DA_n`=1.
    - `clk_DA`=1 while `div_cnt` < CLK_DIV/2.
    - `sync_DA_n`=0 while `base`==0 and `car_cnt`==0.
    - `bit_ready`=1 only on the symbol-end cycle and only when `mode_req`=01.
- At symbol end, `mode_req` is resampled:
  - 00 or 11: go to IDLE the next cycle.
  - 10: `phase`=0 and the symbol continues.
  - 01 with a bit transferred: `phase` is updated from the bit.
  - 01 with no bit available: `phase` is kept, `underrun` pulses, and the symbol continues.
- `mode_req` changes in the middle of a symbol are ignored until the symbol end.
- `bit_valid` outside `bit_ready` does not cause a transfer. The source must hold `bit_in` stable until the transfer completes.
- A reset asserted mid-symbol forces the reset values immediately, asynchronously. After release the block restarts from IDLE, and no partial symbol is resumed.

## Timing
- The address changes one `clk` after each tick. One symbol lasts CLK_DIV×128×CARRIER_PER_SYM `clk` cycles; with the defaults this is 1024.
- LOAD→RUN: on the first RUN cycle, `address`=0 (bit 0) or 64 (bit 1), and `sync_DA_n`=0.
- A phase change takes effect on the first cycle of the next symbol.
- `sym_strobe` and the symbol-end `bit_ready` coincide in the same cycle.

## Configuration
- `MOD_SEQ_DPSK_EN` defined: `phase_next` = `phase` XOR `bit`, giving differential encoding. The reference phase is cleared to 0 on reset and on entry to IDLE.
- `MOD_SEQ_DPSK_EN` undefined: `phase_next` = `bit`, giving absolute BPSK.

## Structure
- Package `mod_seq_pkg` contains:
  - the state enum (IDLE, LOAD, RUN);
  - the `mode_req` constants MODE_IDLE, MODE_BPSK and MODE_CARRIER;
  - the HALF_TABLE offset, 2^(ADDR_W-1).
- Sub-module `sample_tick_gen` holds `div_cnt`, the tick and `clk_DA`/`clk_AD`. It has an enable input, and the counter is held at 0 when the enable is low.

## Test plan
- Reset, then `mode_req`=10: after 4 `clk` cycles `address`=1; `sync_DA_n`=0 for the first 4 cycles; `sym_strobe` occurs at cycle 1023; `underrun` never asserts.
- `mode_req`=01 with bits 1,0,1 always valid: the addresses at the symbol starts are 64, 0, 64; exactly 3 transfers, one per `sym_strobe`.
- `mode_req`=01 with `bit_valid` dropped before the second symbol end: one `underrun` pulse; `phase` is held so the address stays at 64.
- `mode_req` changed to 00 at cycle 500 of a symbol: RUN continues to cycle 1023, then `blank_DA_n`=0 and `busy`=0 on the next cycle.
- `reset_n` asserted low at cycle 300: all outputs take their reset values in the same cycle, with no clock edge needed.
- With `MOD_SEQ_DPSK_EN` defined, bits 1,1,0: the symbol-start addresses are 64, 0, 0.
